trivium_word_ctrl: RTL

Word-level host controller for the serial trivium_top core.
- Accepts a parallel 80-bit key and 80-bit IV, and runs the core's serial load/initialisation protocol.
- Then streams 32-bit plaintext words through the core LSB-first and returns 32-bit ciphertext words over valid/ready handshakes.
- Sits between a bus/host wrapper and trivium_top, and owns all of trivium_top's control inputs.

---
 rtl/trivium_word_ctrl_if.sv | 27 ++
 rtl/trivium_word_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/trivium_word_ctrl_if.sv
// Host-side bundle for trivium_word_ctrl: key/IV session start, plaintext in, ciphertext out.
// master = host/bus wrapper, slave = controller.
interface trivium_word_ctrl_if;
  logic [79:0] key;
  logic [79:0] iv;
  logic        init_vld;
  logic        init_rdy;
  logic [31:0] pt_dat;
  logic        pt_vld;
  logic        pt_rdy;
  logic [31:0] ct_dat;
  logic        ct_vld;
  logic        ct_rdy;
  logic        end_req;
  logic        busy;
  logic        err;

  modport master (
    output key, iv, init_vld, pt_dat, pt_vld, ct_rdy, end_req,
    input  init_rdy, pt_rdy, ct_dat, ct_vld, busy, err
  );

  modport slave (
    input  key, iv, init_vld, pt_dat, pt_vld, ct_rdy, end_req,
    output init_rdy, pt_rdy, ct_dat, ct_vld, busy, err
  );
endinterface

// File: rtl/trivium_word_ctrl.sv
// Word-level controller for the serial trivium core: 161-cycle key/IV load, then 32+OUT_LAT cycles per word.
// Ciphertext is held in a one-word buffer; a new word is refused until the previous one is drained.
module trivium_word_ctrl #(
  parameter int OUT_LAT      = 1,
  parameter int INIT_TIMEOUT = 2048
) (
  input  logic                 clk_i,
  input  logic                 n_rst_i,
  trivium_word_ctrl_if.slave   host,
  output logic                 core_dat_o,
  output logic                 core_get_dat_o,
  output logic                 core_ld_keys_o,
  output logic                 core_end_o,
  input  logic                 core_dat_i,
  input  logic                 core_ready_i
);

  localparam int              TW         = $clog2(INIT_TIMEOUT + 1);
  localparam logic [6:0]      LOAD_LAST  = 7'd79;
  localparam logic [6:0]      WORD_LAST  = 7'd31;
  localparam logic [6:0]      SHIFT_LAST = 7'(31 + OUT_LAT);
  localparam logic [6:0]      LAT        = 7'(OUT_LAT);
  localparam logic [TW-1:0]   TO_LAST    = TW'(INIT_TIMEOUT - 1);
  localparam logic [TW-1:0]   TO_SAT     = TW'(INIT_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_SEND_KEY, S_SEND_IV, S_LOAD, S_WAIT_INIT, S_READY, S_SHIFT, S_END
  } state_t;

  state_t         state, state_nxt;
  logic [6:0]     bit_cnt, bit_cnt_nxt;
  logic [TW-1:0]  to_cnt, to_cnt_nxt;
  logic [79:0]    key_sr, iv_sr;
  logic [31:0]    word_sr, res_sr, ct_dat;
  logic           ct_vld, err;
  logic           init_hs, word_hs, shift_done, set_err;

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
      to_cnt  <= '0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      to_cnt  <= to_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    bit_cnt_nxt    = bit_cnt;
    to_cnt_nxt     = to_cnt;
    init_hs        = 1'b0;
    word_hs        = 1'b0;
    shift_done     = 1'b0;
    set_err        = 1'b0;
    core_dat_o     = 1'b0;
    core_get_dat_o = 1'b0;
    core_ld_keys_o = 1'b0;
    core_end_o     = 1'b0;
    case (state)
      S_IDLE: begin
        if (host.init_vld) begin
          init_hs     = 1'b1;
          bit_cnt_nxt = '0;
          state_nxt   = S_SEND_KEY;
        end
      end
      S_SEND_KEY: begin
        core_get_dat_o = 1'b1;
        core_dat_o     = key_sr[0];
        bit_cnt_nxt    = bit_cnt + 7'd1;
        if (bit_cnt == LOAD_LAST) begin
          bit_cnt_nxt = '0;
          state_nxt   = S_SEND_IV;
        end
      end
      S_SEND_IV: begin
        core_get_dat_o = 1'b1;
        core_dat_o     = iv_sr[0];
        core_ld_keys_o = (bit_cnt == LOAD_LAST);
        bit_cnt_nxt    = bit_cnt + 7'd1;
        if (bit_cnt == LOAD_LAST) begin
          bit_cnt_nxt = '0;
          state_nxt   = S_LOAD;
        end
      end
      S_LOAD: begin
        core_get_dat_o = 1'b1;
        to_cnt_nxt     = '0;
        state_nxt      = S_WAIT_INIT;
      end
      S_WAIT_INIT: begin
        if (core_ready_i) begin
          state_nxt = S_READY;
        end else if (to_cnt == TO_LAST) begin
          set_err   = 1'b1;
          state_nxt = S_IDLE;
        end else if (to_cnt != TO_SAT) begin
          to_cnt_nxt = to_cnt + 1'b1;
        end
      end
      S_READY: begin
        // a word handshake wins over end_req in the same cycle
        if (host.pt_vld && !ct_vld) begin
          word_hs     = 1'b1;
          bit_cnt_nxt = '0;
          state_nxt   = S_SHIFT;
        end else if (host.end_req && !ct_vld) begin
          state_nxt = S_END;
        end
      end
      S_SHIFT: begin
        core_get_dat_o = (bit_cnt <= WORD_LAST);
        core_dat_o     = (bit_cnt <= WORD_LAST) ? word_sr[0] : 1'b0;
        bit_cnt_nxt    = bit_cnt + 7'd1;
        if (bit_cnt == SHIFT_LAST) begin
          shift_done = 1'b1;
          state_nxt  = S_READY;
        end
      end
      S_END: begin
        core_end_o = 1'b1;
        state_nxt  = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      key_sr  <= '0;
      iv_sr   <= '0;
      word_sr <= '0;
      res_sr  <= '0;
      ct_dat  <= '0;
      ct_vld  <= 1'b0;
      err     <= 1'b0;
    end else begin
      if (init_hs) begin
        key_sr <= host.key;
        iv_sr  <= host.iv;
      end else begin
        if (state == S_SEND_KEY) key_sr <= key_sr >> 1;
        if (state == S_SEND_IV)  iv_sr  <= iv_sr >> 1;
      end

      if (init_hs)      err <= 1'b0;
      else if (set_err) err <= 1'b1;

      if (word_hs)                word_sr <= host.pt_dat;
      else if (state == S_SHIFT)  word_sr <= word_sr >> 1;

      // returned bits trail the driven bits by OUT_LAT cycles and arrive LSB first
      if (state == S_SHIFT && bit_cnt >= LAT) res_sr <= {core_dat_i, res_sr[31:1]};

      if (shift_done) begin
        ct_dat <= {core_dat_i, res_sr[31:1]};
        ct_vld <= 1'b1;
      end else if (ct_vld && host.ct_rdy) begin
        ct_vld <= 1'b0;
      end
    end
  end

  assign host.init_rdy = (state == S_IDLE);
  assign host.pt_rdy   = (state == S_READY) && !ct_vld;
  assign host.ct_dat   = ct_dat;
  assign host.ct_vld   = ct_vld;
  assign host.busy     = (state != S_IDLE);
  assign host.err      = err;

endmodule
